// File: rtl/param_bank_ctrl.sv
// param_bank_ctrl: double-buffered parameter RAM controller with frame-aligned bank swap
// and background resync of the shadow bank from the active bank.
module param_bank_ctrl #(
  parameter int PARAM_WIDTH = 36,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  spi_wr_addr,
  input  logic [PARAM_WIDTH-1:0] spi_wr_data,
  input  logic                   spi_wr_enable,
  input  logic                   spi_valid,
  input  logic                   spi_done,
  input  logic                   frame_tick,
  input  logic                   dsp_rd_en,
  input  logic [ADDR_WIDTH-1:0]  dsp_rd_addr,
  output logic [PARAM_WIDTH-1:0] dsp_rd_data,
  output logic                   dsp_rd_valid,
  output logic [ADDR_WIDTH:0]    mem_rd_addr,
  input  logic [PARAM_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH:0]    mem_wr_addr,
  output logic [PARAM_WIDTH-1:0] mem_wr_data,
  output logic                   mem_wr_en,
  input  logic                   clear_status,
  output logic                   active_bank,
  output logic                   busy,
  output logic                   overrun,
  output logic                   abort_err
);
  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;
  state_t                state_q;
  logic                  active_q;
  logic                  dirty_q;
  logic [ADDR_WIDTH:0]   copy_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic                  wr_pend_q;
  logic                  rd_valid_q;
  logic                  overrun_q;
  logic                  abort_q;
  logic                  copy_rd;
  logic                  spi_wr_ok;
  logic                  last_wr;
  logic                  abort_set;
  // Copy reads yield the shared read port to the DSP; the MSB of copy_ptr_q marks all reads issued.
  assign copy_rd     = (state_q == COPY) && !dsp_rd_en && !copy_ptr_q[ADDR_WIDTH];
  assign spi_wr_ok   = (state_q == IDLE) && spi_wr_enable;
  assign last_wr     = wr_pend_q && (wr_ptr_q == '1);
  assign abort_set   = (state_q == IDLE) && spi_done && dirty_q && !spi_valid;
  assign mem_rd_addr = {active_q, dsp_rd_en ? dsp_rd_addr : copy_ptr_q[ADDR_WIDTH-1:0]};
  assign mem_wr_en   = spi_wr_ok | wr_pend_q;
  assign mem_wr_addr = {~active_q, wr_pend_q ? wr_ptr_q : spi_wr_addr};
  assign mem_wr_data = wr_pend_q ? mem_rd_data : spi_wr_data;
  assign dsp_rd_data  = mem_rd_data;
  assign dsp_rd_valid = rd_valid_q;
  assign active_bank  = active_q;
  assign busy         = state_q != IDLE;
  assign overrun      = overrun_q;
  assign abort_err    = abort_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      active_q   <= 1'b0;
      dirty_q    <= 1'b0;
      copy_ptr_q <= '0;
      wr_ptr_q   <= '0;
      wr_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rd_valid_q <= dsp_rd_en;
      wr_pend_q  <= copy_rd;
      if (copy_rd) begin
        wr_ptr_q   <= copy_ptr_q[ADDR_WIDTH-1:0];
        copy_ptr_q <= copy_ptr_q + 1'b1;
      end
      overrun_q <= (spi_wr_enable && state_q != IDLE) | (overrun_q & ~clear_status);
      abort_q   <= abort_set | (abort_q & ~clear_status);
      case (state_q)
        IDLE: begin
          if (spi_wr_enable) dirty_q <= 1'b1;
          if (spi_done && dirty_q) begin
            state_q    <= spi_valid ? PENDING : COPY;
            copy_ptr_q <= '0;
          end
        end
        PENDING: if (frame_tick) begin
          active_q   <= ~active_q;
          copy_ptr_q <= '0;
          state_q    <= COPY;
        end
        COPY: if (last_wr) begin
          dirty_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
